// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter sharing one alu, with registered operand steering and response
module alu_arbiter #(
    parameter int XLEN      = 32,
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [XLEN-1:0] req0_op1,
    input  logic [XLEN-1:0] req0_op2,
    input  logic [2:0]      req0_funct3,
    input  logic            req0_funct7,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [XLEN-1:0] req1_op1,
    input  logic [XLEN-1:0] req1_op2,
    input  logic [2:0]      req1_funct3,
    input  logic            req1_funct7,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            busy,
    output logic [XLEN-1:0] adder_op1,
    output logic [XLEN-1:0] adder_op2,
    output logic [XLEN-1:0] shifter_op1,
    output logic [XLEN-1:0] shifter_op2,
    output logic [XLEN-1:0] comperator_op1,
    output logic [XLEN-1:0] comperator_op2,
    output logic [2:0]      funct3,
    output logic            funct7,
    input  logic [XLEN-1:0] adder_rsv,
    input  logic [XLEN-1:0] shifter_rsv,
    input  logic [XLEN-1:0] comparator_rsv
);

    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t          state;
    logic            last_grant;
    logic            owner;
    logic            grant;
    logic            fire;
    logic [XLEN-1:0] in_op1;
    logic [XLEN-1:0] in_op2;
    logic [2:0]      in_f3;
    logic            in_f7;

    function automatic logic is_shift(input logic [2:0] f);
        return (f == 3'b001) || (f == 3'b101);
    endfunction

    function automatic logic is_cmp(input logic [2:0] f);
        return (f == 3'b010) || (f == 3'b011);
    endfunction

    // grant = 1 selects requester 1; round-robin favours whoever was not served last
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid)
            grant = RR_ENABLE ? ~last_grant : 1'b0;
        else if (req1_valid)
            grant = 1'b1;
    end

    assign req0_ready = !rst && (state == IDLE) && req0_valid && !grant;
    assign req1_ready = !rst && (state == IDLE) && req1_valid && grant;
    assign fire       = req0_ready || req1_ready;
    assign busy       = (state != IDLE);

    assign in_op1 = grant ? req1_op1    : req0_op1;
    assign in_op2 = grant ? req1_op2    : req0_op2;
    assign in_f3  = grant ? req1_funct3 : req0_funct3;
    assign in_f7  = grant ? req1_funct7 : req0_funct7;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            last_grant     <= 1'b1;
            owner          <= 1'b0;
            rsp0_valid     <= 1'b0;
            rsp1_valid     <= 1'b0;
            rsp_data       <= '0;
            adder_op1      <= '0;
            adder_op2      <= '0;
            shifter_op1    <= '0;
            shifter_op2    <= '0;
            comperator_op1 <= '0;
            comperator_op2 <= '0;
            funct3         <= '0;
            funct7         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fire) begin
                        // operand ports double as the captured request during EXEC
                        owner          <= grant;
                        adder_op1      <= (!is_shift(in_f3) && !is_cmp(in_f3)) ? in_op1 : '0;
                        adder_op2      <= (!is_shift(in_f3) && !is_cmp(in_f3)) ? in_op2 : '0;
                        shifter_op1    <= is_shift(in_f3) ? in_op1 : '0;
                        shifter_op2    <= is_shift(in_f3) ? in_op2 : '0;
                        comperator_op1 <= is_cmp(in_f3) ? in_op1 : '0;
                        comperator_op2 <= is_cmp(in_f3) ? in_op2 : '0;
                        funct3         <= in_f3;
                        funct7         <= ((in_f3 == 3'b000) || (in_f3 == 3'b101)) ? in_f7 : 1'b0;
                        state          <= EXEC;
                    end
                end
                EXEC: begin
                    if (is_shift(funct3))
                        rsp_data <= shifter_rsv;
                    else if (is_cmp(funct3))
                        rsp_data <= comparator_rsv;
                    else
                        rsp_data <= adder_rsv;
                    adder_op1      <= '0;
                    adder_op2      <= '0;
                    shifter_op1    <= '0;
                    shifter_op2    <= '0;
                    comperator_op1 <= '0;
                    comperator_op2 <= '0;
                    funct3         <= '0;
                    funct7         <= 1'b0;
                    rsp0_valid     <= !owner;
                    rsp1_valid     <= owner;
                    state          <= RESP;
                end
                RESP: begin
                    if ((!owner && rsp0_ready) || (owner && rsp1_ready)) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        last_grant <= owner;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - randomized and directed self-checking bench for alu_arbiter
module tb_alu_arbiter;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;
        logic        f7;
    } op_t;

    typedef struct {
        logic        rdy0, rdy1;
        logic [31:0] ad1, ad2, sh1, sh2, cp1, cp2;
        logic [2:0]  f3;
        logic        f7;
        logic        busy_exec;
        logic        rv0, rv1;
        logic [31:0] data;
        logic        busy_after, rv_after;
    } snap_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req0_valid, req1_valid, rsp0_ready, rsp1_ready;
    logic [31:0] req0_op1, req0_op2, req1_op1, req1_op2;
    logic [2:0]  req0_funct3, req1_funct3;
    logic        req0_funct7, req1_funct7;

    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy, funct7;
    logic [31:0] rsp_data, adder_op1, adder_op2, shifter_op1, shifter_op2, comperator_op1, comperator_op2;
    logic [2:0]  funct3;
    logic [31:0] adder_rsv, shifter_rsv, comparator_rsv;

    logic        fp_req0_ready, fp_req1_ready, fp_rsp0_valid, fp_rsp1_valid, fp_busy, fp_funct7;
    logic [31:0] fp_rsp_data, fp_adder_op1, fp_adder_op2, fp_shifter_op1, fp_shifter_op2;
    logic [31:0] fp_comperator_op1, fp_comperator_op2;
    logic [2:0]  fp_funct3;
    logic [31:0] fp_adder_rsv, fp_shifter_rsv, fp_comparator_rsv;

    int checks = 0;
    int failures = 0;

    // RV32 result of an operation, straight from the instruction semantics
    function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f3, input logic f7);
        case (f3)
            3'd0:    return f7 ? a - b : a + b;
            3'd1:    return a << b[4:0];
            3'd2:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3:    return (a < b) ? 32'd1 : 32'd0;
            3'd4:    return a ^ b;
            3'd5:    return f7 ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
            3'd6:    return a | b;
            default: return a & b;
        endcase
    endfunction

    // each alu sub-unit only knows its own operations; anything else yields a marker
    function automatic logic [31:0] unit_res(input int unit, input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] f3, input logic f7);
        int u;
        u = (f3 == 3'd1 || f3 == 3'd5) ? 1 : (f3 == 3'd2 || f3 == 3'd3) ? 2 : 0;
        if (u != unit) return 32'hBAD0_0000 + 32'(unit);
        return ref_alu(a, b, f3, f7);
    endfunction

    assign adder_rsv         = unit_res(0, adder_op1, adder_op2, funct3, funct7);
    assign shifter_rsv       = unit_res(1, shifter_op1, shifter_op2, funct3, funct7);
    assign comparator_rsv    = unit_res(2, comperator_op1, comperator_op2, funct3, funct7);
    assign fp_adder_rsv      = unit_res(0, fp_adder_op1, fp_adder_op2, fp_funct3, fp_funct7);
    assign fp_shifter_rsv    = unit_res(1, fp_shifter_op1, fp_shifter_op2, fp_funct3, fp_funct7);
    assign fp_comparator_rsv = unit_res(2, fp_comperator_op1, fp_comperator_op2, fp_funct3, fp_funct7);

    alu_arbiter #(.XLEN(32), .RR_ENABLE(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op1(req0_op1), .req0_op2(req0_op2),
        .req0_funct3(req0_funct3), .req0_funct7(req0_funct7),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op1(req1_op1), .req1_op2(req1_op2),
        .req1_funct3(req1_funct3), .req1_funct7(req1_funct7),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(rsp_data), .busy(busy),
        .adder_op1(adder_op1), .adder_op2(adder_op2), .shifter_op1(shifter_op1), .shifter_op2(shifter_op2),
        .comperator_op1(comperator_op1), .comperator_op2(comperator_op2),
        .funct3(funct3), .funct7(funct7),
        .adder_rsv(adder_rsv), .shifter_rsv(shifter_rsv), .comparator_rsv(comparator_rsv)
    );

    alu_arbiter #(.XLEN(32), .RR_ENABLE(1'b0)) u_fp (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(fp_req0_ready), .req0_op1(req0_op1), .req0_op2(req0_op2),
        .req0_funct3(req0_funct3), .req0_funct7(req0_funct7),
        .req1_valid(req1_valid), .req1_ready(fp_req1_ready), .req1_op1(req1_op1), .req1_op2(req1_op2),
        .req1_funct3(req1_funct3), .req1_funct7(req1_funct7),
        .rsp0_valid(fp_rsp0_valid), .rsp0_ready(rsp0_ready), .rsp1_valid(fp_rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp_data(fp_rsp_data), .busy(fp_busy),
        .adder_op1(fp_adder_op1), .adder_op2(fp_adder_op2), .shifter_op1(fp_shifter_op1), .shifter_op2(fp_shifter_op2),
        .comperator_op1(fp_comperator_op1), .comperator_op2(fp_comperator_op2),
        .funct3(fp_funct3), .funct7(fp_funct7),
        .adder_rsv(fp_adder_rsv), .shifter_rsv(fp_shifter_rsv), .comparator_rsv(fp_comparator_rsv)
    );

    bit use_fp = 1'b0;
    bit bp = 1'b0;
    logic s_req0_ready, s_req1_ready, s_rsp0_valid, s_rsp1_valid;
    logic [31:0] s_rsp_data;
    assign s_req0_ready = use_fp ? fp_req0_ready : req0_ready;
    assign s_req1_ready = use_fp ? fp_req1_ready : req1_ready;
    assign s_rsp0_valid = use_fp ? fp_rsp0_valid : rsp0_valid;
    assign s_rsp1_valid = use_fp ? fp_rsp1_valid : rsp1_valid;
    assign s_rsp_data   = use_fp ? fp_rsp_data   : rsp_data;

    op_t         q0[$], q1[$];
    int          grants[$], r_own[$], e_own[$];
    logic [31:0] r_dat[$], e_dat[$];
    bit          arb_to;

    function automatic op_t mk(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3, input logic f7);
        op_t o;
        o.a = a; o.b = b; o.f3 = f3; o.f7 = f7;
        return o;
    endfunction

    function automatic op_t rnd_op();
        return mk($urandom, $urandom, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // both requesters present their queued ops back to back; grants and responses are recorded
    task automatic arb_run();
        int i0 = 0;
        int i1 = 0;
        int n;
        int cyc = 0;
        grants.delete(); r_own.delete(); r_dat.delete(); e_own.delete(); e_dat.delete();
        n = q0.size() + q1.size();
        while (r_own.size() < n && cyc < 600) begin
            @(negedge clk);
            req0_valid = (i0 < q0.size());
            req1_valid = (i1 < q1.size());
            if (req0_valid) begin
                req0_op1 = q0[i0].a; req0_op2 = q0[i0].b; req0_funct3 = q0[i0].f3; req0_funct7 = q0[i0].f7;
            end
            if (req1_valid) begin
                req1_op1 = q1[i1].a; req1_op2 = q1[i1].b; req1_funct3 = q1[i1].f3; req1_funct7 = q1[i1].f7;
            end
            rsp0_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            rsp1_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (s_rsp0_valid && rsp0_ready) begin r_own.push_back(0); r_dat.push_back(s_rsp_data); end
            if (s_rsp1_valid && rsp1_ready) begin r_own.push_back(1); r_dat.push_back(s_rsp_data); end
            if (req0_valid && s_req0_ready) begin
                grants.push_back(0); e_own.push_back(0);
                e_dat.push_back(ref_alu(q0[i0].a, q0[i0].b, q0[i0].f3, q0[i0].f7)); i0++;
            end
            if (req1_valid && s_req1_ready) begin
                grants.push_back(1); e_own.push_back(1);
                e_dat.push_back(ref_alu(q1[i1].a, q1[i1].b, q1[i1].f3, q1[i1].f7)); i1++;
            end
            cyc++;
        end
        arb_to = (r_own.size() < n);
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    endtask

    task automatic one_op(input int id, input op_t o, output snap_t s);
        @(negedge clk);
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        if (id == 0) begin
            req0_valid = 1'b1; req0_op1 = o.a; req0_op2 = o.b; req0_funct3 = o.f3; req0_funct7 = o.f7;
        end else begin
            req1_valid = 1'b1; req1_op1 = o.a; req1_op2 = o.b; req1_funct3 = o.f3; req1_funct7 = o.f7;
        end
        #1;
        s.rdy0 = req0_ready; s.rdy1 = req1_ready;
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        s.ad1 = adder_op1; s.ad2 = adder_op2; s.sh1 = shifter_op1; s.sh2 = shifter_op2;
        s.cp1 = comperator_op1; s.cp2 = comperator_op2; s.f3 = funct3; s.f7 = funct7; s.busy_exec = busy;
        @(negedge clk);
        #1;
        s.rv0 = rsp0_valid; s.rv1 = rsp1_valid; s.data = rsp_data;
        @(negedge clk);
        #1;
        s.busy_after = busy; s.rv_after = rsp0_valid | rsp1_valid;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL rst_ready0 got=%b exp=0", req0_ready); end
        checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL rst_ready1 got=%b exp=0", req1_ready); end
        @(negedge clk);
        #1;
        checks++; if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin failures++; $display("FAIL rst_flags got=%b exp=000", {busy, rsp0_valid, rsp1_valid}); end
        checks++; if (rsp_data !== 32'd0) begin failures++; $display("FAIL rst_data got=%h exp=0", rsp_data); end
        checks++; if ((adder_op1 | adder_op2 | shifter_op1 | shifter_op2 | comperator_op1 | comperator_op2) !== 32'd0 ||
                      funct3 !== 3'd0 || funct7 !== 1'b0) begin
            failures++; $display("FAIL rst_ports got=%h/%h exp=0", adder_op1, funct3);
        end
        rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    endtask

    task automatic test_add();
        snap_t s;
        one_op(0, mk(32'd100, 32'd100, 3'd0, 1'b0), s);
        checks++; if ({s.rdy0, s.rdy1} !== 2'b10) begin failures++; $display("FAIL add_ready got=%b exp=10", {s.rdy0, s.rdy1}); end
        checks++; if (s.ad1 !== 32'd100 || s.ad2 !== 32'd100) begin failures++; $display("FAIL add_ports got=%0d,%0d exp=100,100", s.ad1, s.ad2); end
        checks++; if ((s.sh1 | s.sh2 | s.cp1 | s.cp2) !== 32'd0) begin failures++; $display("FAIL add_other_ports got=%h exp=0", s.sh1 | s.sh2 | s.cp1 | s.cp2); end
        checks++; if (s.busy_exec !== 1'b1) begin failures++; $display("FAIL add_busy got=%b exp=1", s.busy_exec); end
        checks++; if ({s.rv0, s.rv1} !== 2'b10) begin failures++; $display("FAIL add_rsp_valid got=%b exp=10", {s.rv0, s.rv1}); end
        checks++; if (s.data !== 32'd200) begin failures++; $display("FAIL add_data got=%0d exp=200", s.data); end
        checks++; if ({s.busy_after, s.rv_after} !== 2'b00) begin failures++; $display("FAIL add_after got=%b exp=00", {s.busy_after, s.rv_after}); end
    endtask

    task automatic test_sub_or();
        snap_t s;
        one_op(1, mk(32'd100, 32'd100, 3'd0, 1'b1), s);
        checks++; if (s.rdy1 !== 1'b1) begin failures++; $display("FAIL sub_ready got=%b exp=1", s.rdy1); end
        checks++; if (s.f7 !== 1'b1) begin failures++; $display("FAIL sub_funct7 got=%b exp=1", s.f7); end
        checks++; if ({s.rv0, s.rv1} !== 2'b01) begin failures++; $display("FAIL sub_rsp_valid got=%b exp=01", {s.rv0, s.rv1}); end
        checks++; if (s.data !== 32'd0) begin failures++; $display("FAIL sub_data got=%0d exp=0", s.data); end
        one_op(1, mk(32'd100, 32'd100, 3'd6, 1'b1), s);
        checks++; if (s.f7 !== 1'b0 || s.f3 !== 3'd6) begin failures++; $display("FAIL or_funct got=%b/%0d exp=0/6", s.f7, s.f3); end
        checks++; if (s.data !== 32'd100) begin failures++; $display("FAIL or_data got=%0d exp=100", s.data); end
    endtask

    task automatic test_steering();
        snap_t s;
        one_op(0, mk(32'h8000_0000, 32'd4, 3'd5, 1'b1), s);
        checks++; if (s.sh1 !== 32'h8000_0000 || s.sh2 !== 32'd4 || (s.ad1 | s.cp1) !== 32'd0) begin
            failures++; $display("FAIL sra_ports got=%h,%h,%h exp=80000000,4,0", s.sh1, s.sh2, s.ad1 | s.cp1);
        end
        checks++; if (s.f7 !== 1'b1) begin failures++; $display("FAIL sra_funct7 got=%b exp=1", s.f7); end
        checks++; if (s.data !== 32'hF800_0000) begin failures++; $display("FAIL sra_data got=%h exp=f8000000", s.data); end
        one_op(1, mk(32'hFFFF_FFFF, 32'd1, 3'd2, 1'b0), s);
        checks++; if (s.cp1 !== 32'hFFFF_FFFF || s.cp2 !== 32'd1 || (s.ad1 | s.sh1) !== 32'd0) begin
            failures++; $display("FAIL slt_ports got=%h,%h exp=ffffffff,1", s.cp1, s.cp2);
        end
        checks++; if (s.data !== 32'd1) begin failures++; $display("FAIL slt_data got=%0d exp=1", s.data); end
        one_op(0, mk(32'hFFFF_FFFF, 32'd1, 3'd3, 1'b0), s);
        checks++; if (s.data !== 32'd0) begin failures++; $display("FAIL sltu_data got=%0d exp=0", s.data); end
    endtask

    task automatic test_round_robin();
        do_reset();
        use_fp = 1'b0; bp = 1'b0;
        q0.delete(); q1.delete();
        for (int i = 0; i < 2; i++) begin q0.push_back(rnd_op()); q1.push_back(rnd_op()); end
        arb_run();
        checks++; if (arb_to) begin failures++; $display("FAIL rr_timeout got=%0d exp=4 responses", r_own.size()); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (i >= grants.size() || grants[i] !== (i % 2)) begin
                failures++; $display("FAIL rr_grant[%0d] got=%0d exp=%0d", i, (i < grants.size()) ? grants[i] : -1, i % 2);
            end
        end
        for (int i = 0; i < r_dat.size() && i < e_dat.size(); i++) begin
            checks++; if (r_dat[i] !== e_dat[i] || r_own[i] !== e_own[i]) begin
                failures++; $display("FAIL rr_rsp[%0d] got=%0d:%h exp=%0d:%h", i, r_own[i], r_dat[i], e_own[i], e_dat[i]);
            end
        end
    endtask

    task automatic test_fixed_priority();
        do_reset();
        use_fp = 1'b1; bp = 1'b0;
        q0.delete(); q1.delete();
        for (int i = 0; i < 4; i++) q0.push_back(rnd_op());
        q1.push_back(rnd_op());
        arb_run();
        checks++; if (arb_to) begin failures++; $display("FAIL fp_timeout got=%0d exp=5 responses", r_own.size()); end
        for (int i = 0; i < 5; i++) begin
            checks++; if (i >= grants.size() || grants[i] !== ((i == 4) ? 1 : 0)) begin
                failures++; $display("FAIL fp_grant[%0d] got=%0d exp=%0d", i, (i < grants.size()) ? grants[i] : -1, (i == 4) ? 1 : 0);
            end
        end
        for (int i = 0; i < r_dat.size() && i < e_dat.size(); i++) begin
            checks++; if (r_dat[i] !== e_dat[i] || r_own[i] !== e_own[i]) begin
                failures++; $display("FAIL fp_rsp[%0d] got=%0d:%h exp=%0d:%h", i, r_own[i], r_dat[i], e_own[i], e_dat[i]);
            end
        end
        use_fp = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        @(negedge clk);
        req0_valid = 1'b1; req0_op1 = 32'd7; req0_op2 = 32'd5; req0_funct3 = 3'd0; req0_funct7 = 1'b0;
        req1_valid = 1'b1; req1_op1 = 32'd1; req1_op2 = 32'd2; req1_funct3 = 3'd0; req1_funct7 = 1'b0;
        rsp0_ready = 1'b0; rsp1_ready = 1'b1;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++; $display("FAIL bp_grant got=%b exp=10", {req0_ready, req1_ready}); end
        @(negedge clk);
        req0_valid = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (rsp0_valid !== 1'b1 || rsp_data !== 32'd12 || req1_ready !== 1'b0) begin
                failures++; $display("FAIL bp_hold[%0d] got=%b,%0d,%b exp=1,12,0", i, rsp0_valid, rsp_data, req1_ready);
            end
            @(negedge clk);
        end
        rsp0_ready = 1'b1;
        #1;
        checks++; if (req1_ready !== 1'b0) begin failures++; $display("FAIL bp_release_ready got=%b exp=0", req1_ready); end
        @(negedge clk);
        #1;
        checks++; if ({busy, rsp0_valid, req1_ready} !== 3'b001) begin failures++; $display("FAIL bp_idle got=%b exp=001", {busy, rsp0_valid, req1_ready}); end
        @(negedge clk);
        req1_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++; if (rsp1_valid !== 1'b1 || rsp_data !== 32'd3) begin failures++; $display("FAIL bp_req1_rsp got=%b,%0d exp=1,3", rsp1_valid, rsp_data); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_exec();
        @(negedge clk);
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req1_valid = 1'b1; req1_op1 = 32'd5; req1_op2 = 32'd6; req1_funct3 = 3'd0; req1_funct7 = 1'b0;
        @(negedge clk);
        req1_valid = 1'b0;
        #1;
        checks++; if (busy !== 1'b1 || adder_op1 !== 32'd5) begin failures++; $display("FAIL mid_exec got=%b,%0d exp=1,5", busy, adder_op1); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if ({busy, rsp0_valid, rsp1_valid} !== 3'b000 || rsp_data !== 32'd0) begin
            failures++; $display("FAIL mid_rst_state got=%b,%h exp=000,0", {busy, rsp0_valid, rsp1_valid}, rsp_data);
        end
        checks++; if ((adder_op1 | adder_op2 | shifter_op1 | shifter_op2 | comperator_op1 | comperator_op2) !== 32'd0) begin
            failures++; $display("FAIL mid_rst_ports got=%h exp=0", adder_op1 | adder_op2);
        end
        req0_valid = 1'b1; req0_op1 = 32'd1; req0_op2 = 32'd1; req0_funct3 = 3'd0; req0_funct7 = 1'b0;
        req1_valid = 1'b1; req1_op1 = 32'd2; req1_op2 = 32'd2; req1_funct3 = 3'd0; req1_funct7 = 1'b0;
        #1;
        checks++; if ({req0_ready, req1_ready} !== 2'b10) begin failures++; $display("FAIL mid_rst_grant got=%b exp=10", {req0_ready, req1_ready}); end
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        @(negedge clk);
        #1;
        checks++; if ({rsp0_valid, rsp1_valid} !== 2'b10 || rsp_data !== 32'd2) begin
            failures++; $display("FAIL mid_rst_rsp got=%b,%0d exp=10,2", {rsp0_valid, rsp1_valid}, rsp_data);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        do_reset();
        use_fp = 1'b0; bp = 1'b1;
        q0.delete(); q1.delete();
        for (int i = 0; i < 15; i++) begin q0.push_back(rnd_op()); q1.push_back(rnd_op()); end
        arb_run();
        bp = 1'b0;
        checks++; if (arb_to || r_own.size() !== e_own.size()) begin
            failures++; $display("FAIL rnd_count got=%0d exp=%0d", r_own.size(), e_own.size());
        end
        for (int i = 0; i < r_dat.size() && i < e_dat.size(); i++) begin
            checks++; if (r_dat[i] !== e_dat[i] || r_own[i] !== e_own[i]) begin
                failures++; $display("FAIL rnd_rsp[%0d] got=%0d:%h exp=%0d:%h", i, r_own[i], r_dat[i], e_own[i], e_dat[i]);
            end
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        req0_op1 = '0; req0_op2 = '0; req0_funct3 = '0; req0_funct7 = 1'b0;
        req1_op1 = '0; req1_op2 = '0; req1_funct3 = '0; req1_funct7 = 1'b0;
        test_reset();
        test_add();
        test_sub_or();
        test_steering();
        test_round_robin();
        test_fixed_priority();
        test_backpressure();
        test_reset_mid_exec();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single `alu` instance (adder, shifter and comparator sub-units, funct3/funct7 decode) between two requesters, e.g. the execute stage (req0) and the branch/address unit (req1).
- Accepts one operation at a time over a valid/ready handshake and steers the operands to the sub-unit that funct3 selects.
- Registers the selected sub-unit result and returns it to the requester that issued the operation.

Parameters:
XLEN, 32, operand/result width; must match the `alu` datapath (32).
RR_ENABLE, 1, 1 = round-robin grant; 0 = fixed priority, req0 always wins.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
req0_valid  input  1  requester 0 has an operation
req0_ready  output  1  arbiter accepts requester 0 this cycle
req0_op1  input  XLEN  requester 0 operand 1
req0_op2  input  XLEN  requester 0 operand 2
req0_funct3  input  3  requester 0 RV32 funct3
req0_funct7  input  1  requester 0 funct7 bit 5 (sub/sra select)
req1_valid, req1_ready, req1_op1, req1_op2, req1_funct3, req1_funct7: as req0, for requester 1
rsp0_valid  output  1  result for requester 0 is available
rsp0_ready  input  1  requester 0 takes the result
rsp1_valid  output  1  result for requester 1 is available
rsp1_ready  input  1  requester 1 takes the result
rsp_data  output  XLEN  registered result, shared by both response channels
busy  output  1  high in every state except IDLE
adder_op1, adder_op2  output  XLEN  to alu adder/logic path
shifter_op1, shifter_op2  output  XLEN  to alu shifter
comperator_op1, comperator_op2  output  XLEN  to alu comparator
funct3  output  3  to alu
funct7  output  1  to alu
adder_rsv, shifter_rsv, comparator_rsv  input  XLEN  from alu

Behaviour:
- Reset (rst high at a clk edge):
  - state = IDLE; last_grant = 1, so req0 wins first.
  - rsp0_valid = rsp1_valid = 0; rsp_data = 0; busy = 0.
  - All alu operand ports, funct3 and funct7 = 0.
  - reqN_ready = 0 for any cycle in which rst is high.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant is computed combinationally from reqN_valid.
  - Only the granted requester sees ready = 1.
  - Both valid with RR_ENABLE = 1: grant goes to the requester that is not last_grant. With RR_ENABLE = 0: req0.
  - Fire = valid && ready. On fire, capture op1, op2, funct3, funct7 and the owner id, then go to EXEC.
  - No valid: stay in IDLE.
- EXEC (exactly 1 cycle):
  - Drive the captured operands to one sub-unit; the other two sub-units' operand ports are driven to 0.
  - Unit select by funct3: 000, 100, 110, 111 -> adder ports; 001, 101 -> shifter ports; 010, 011 -> comperator ports.
  - funct3 port = captured funct3.
  - funct7 port = captured funct7 only when funct3 is 000 or 101; otherwise 0.
  - At the clock edge, rsp_data <= the selected sub-unit result (adder_rsv, shifter_rsv or comparator_rsv). Go to RESP.
- RESP:
  - rspN_valid = 1 for the owner only; rsp_data is held stable.
  - On rspN_ready: set last_grant = owner, go to IDLE, and clear rspN_valid at the next edge.
  - The other requester's valid is ignored while in RESP; no request is accepted in the same cycle as a response handshake.
- Latency: request fire at cycle N -> rsp valid at N+2 -> earliest next accept at N+3 (3-cycle minimum throughput).
- Backpressure: rspN_ready low holds RESP indefinitely, with rsp_data and rspN_valid constant.
- Requester hold rule: once valid is asserted, the requester holds its operands until ready. The arbiter never takes a request that was dropped before ready.
- rsp_data after the handshake: keeps its last value until the next EXEC capture.
- Reset mid-operation (EXEC or RESP): the transaction is discarded and no response is issued. Post-reset outputs are as listed under Reset.
- Width: the arbiter performs no arithmetic. Shift amount masking (op2 % 32) and signedness are the alu's job; the arbiter passes operands unmodified.

Test Plan:
- Add on req0: op1 = 100, op2 = 100, funct3 = 000, funct7 = 0 -> adder_op1 = adder_op2 = 100 in EXEC, shifter/comperator ports 0; rsp0_valid at N+2 with rsp_data = 200; rsp1_valid stays 0.
- Sub on req1 (req0 idle): 100 - 100, funct7 = 1 -> funct7 port = 1 in EXEC; rsp1_valid with rsp_data = 0. Then an OR (funct3 = 110, funct7 = 1) -> funct7 port 0, result 100.
- Simultaneous req0 and req1 valid for 4 transactions, RR_ENABLE = 1 -> grant order 0, 1, 0, 1. Repeat with RR_ENABLE = 0 -> 0, 0, 0, 0 while req0 is held valid.
- Shifter/comparator steering:
  - sra 0x80000000 by 4 (funct3 = 101, funct7 = 1) -> shifter ports used, rsp_data = 0xF8000000.
  - slt 0xFFFFFFFF vs 1 (funct3 = 010) -> 1.
  - sltu 0xFFFFFFFF vs 1 (funct3 = 011) -> 0.
- Backpressure: rsp0_ready low for 5 cycles -> rsp0_valid and rsp_data stable, req1_ready = 0 throughout; rsp0_ready high -> IDLE next cycle, req1 granted.
- Reset mid-EXEC: assert rst for 1 cycle during EXEC -> next cycle in IDLE, busy = 0, all operand ports 0, no rspN_valid; next request is granted to req0.
